// File: rtl/dpram_pkg.sv
// Shared types and defaults for the dual-port RAM initiator controller.
package dpram_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DEPTH  = 16;
  localparam int unsigned DEF_CNT_W  = 8;

  // Per-port request/response sequencing.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RSP     = 2'd2
  } port_state_e;

  // True when the address names a real RAM word; callers zero-extend to 32 bits.
  function automatic logic in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/ram_port_agent.sv
// One RAM port's initiator: request handshake, RAM drive, one-deep read
// response register and the IDLE/RD_WAIT/RSP sequencing for that port.
module ram_port_agent
  import dpram_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  // request channel
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  // arbitration: block withholds ready; ready_raw is ready before blocking
  input  logic              block,
  output logic              ready_raw,
  // response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  // RAM port
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_wen,
  input  logic [DATA_W-1:0] ram_dout
);

  port_state_e       state_q, state_d;
  logic              err_pend_q, err_pend_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic accept;
  logic rd_accept;
  logic addr_ok;

  // Handshake and RAM drive are purely combinational from the request.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a value on every path
    // (defaults first); a missed branch would otherwise infer a latch.
    ready_raw = 1'b0;
    if (!rst) begin
      ready_raw = (state_q == IDLE) || ((state_q == RSP) && rsp_ready);
    end
    req_ready = ready_raw && !block;
    accept    = req_valid && req_ready;
    rd_accept = accept && !req_we;
    addr_ok   = in_range(32'(req_addr), DEPTH);
    ram_addr  = accept ? req_addr  : '0;
    ram_din   = accept ? req_wdata : '0;
    ram_wen   = accept && req_we && addr_ok;
  end

  // Next-state and response-register logic. An out-of-range read takes the
  // same one-cycle wait slot as a real read, with err_pend acting as the
  // delay bit, so its error response lands with identical latency.
  always_comb begin
    state_d    = state_q;
    err_pend_d = err_pend_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (rd_accept) begin
          state_d    = RD_WAIT;
          err_pend_d = !addr_ok;
        end
      end
      RD_WAIT: begin
        // RAM loaded dout at the accept edge; capture it now.
        state_d    = RSP;
        rsp_data_d = err_pend_q ? '0 : ram_dout;
        rsp_err_d  = err_pend_q;
        err_pend_d = 1'b0;
      end
      RSP: begin
        // Response data/err hold until the consumer takes them.
        if (rsp_ready) begin
          if (rd_accept) begin
            state_d    = RD_WAIT;
            err_pend_d = !addr_ok;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and response registers with synchronous reset; in-flight reads vanish.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= IDLE;
      err_pend_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_pend_q <= err_pend_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign rsp_valid = (state_q == RSP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: rtl/dual_port_ram_ctrl.sv
// Initiator-side controller for the 8-bit dual-port RAM: two request channels
// mapped onto RAM ports 1 (A) and 2 (B), with same-address write arbitration
// (A wins) and a saturating collision counter.
module dual_port_ram_ctrl
  import dpram_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  // port A
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic              a_req_we,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [DATA_W-1:0] a_req_wdata,
  output logic              a_rsp_valid,
  input  logic              a_rsp_ready,
  output logic [DATA_W-1:0] a_rsp_data,
  output logic              a_rsp_err,
  // port B
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic              b_req_we,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [DATA_W-1:0] b_req_wdata,
  output logic              b_rsp_valid,
  input  logic              b_rsp_ready,
  output logic [DATA_W-1:0] b_rsp_data,
  output logic              b_rsp_err,
  // RAM
  output logic [ADDR_W-1:0] ram_addr1,
  output logic [ADDR_W-1:0] ram_addr2,
  output logic [DATA_W-1:0] ram_din1,
  output logic [DATA_W-1:0] ram_din2,
  output logic              ram_wen1,
  output logic              ram_wen2,
  input  logic [DATA_W-1:0] ram_dout1,
  input  logic [DATA_W-1:0] ram_dout2,
  // status
  output logic [CNT_W-1:0]  collision_cnt
);

  logic             a_ready_raw;
  logic             b_ready_raw;
  logic             collision;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Write-write collision: both ports would accept a write to the same
  // in-range address this cycle. Compare uses the full address width.
  always_comb begin
    collision = a_req_valid && a_req_we && a_ready_raw &&
                b_req_valid && b_req_we && b_ready_raw &&
                (a_req_addr == b_req_addr) &&
                in_range(32'(a_req_addr), DEPTH);
  end

  // Collision counter next value, saturating at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (collision && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Collision counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign collision_cnt = cnt_q;

  ram_port_agent #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_port_a (
    .clk       (clk),
    .rst       (rst),
    .req_valid (a_req_valid),
    .req_ready (a_req_ready),
    .req_we    (a_req_we),
    .req_addr  (a_req_addr),
    .req_wdata (a_req_wdata),
    .block     (1'b0),
    .ready_raw (a_ready_raw),
    .rsp_valid (a_rsp_valid),
    .rsp_ready (a_rsp_ready),
    .rsp_data  (a_rsp_data),
    .rsp_err   (a_rsp_err),
    .ram_addr  (ram_addr1),
    .ram_din   (ram_din1),
    .ram_wen   (ram_wen1),
    .ram_dout  (ram_dout1)
  );

  // B loses collisions: its ready drops for that cycle and it retries.
  ram_port_agent #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_port_b (
    .clk       (clk),
    .rst       (rst),
    .req_valid (b_req_valid),
    .req_ready (b_req_ready),
    .req_we    (b_req_we),
    .req_addr  (b_req_addr),
    .req_wdata (b_req_wdata),
    .block     (collision),
    .ready_raw (b_ready_raw),
    .rsp_valid (b_rsp_valid),
    .rsp_ready (b_rsp_ready),
    .rsp_data  (b_rsp_data),
    .rsp_err   (b_rsp_err),
    .ram_addr  (ram_addr2),
    .ram_din   (ram_din2),
    .ram_wen   (ram_wen2),
    .ram_dout  (ram_dout2)
  );

endmodule
